pipeline_exec_ctrl: RTL
=======================

Name: pipeline_exec_ctrl

Overview:
- Execution sequencer for the 5-stage MIPS pipeline.
- Accepts RUN / STEP / STOP / CLEAR commands from the debug host over a valid/ready handshake.
- Drives the global stage enable and the fetch enable, and inserts IF/ID bubbles.
- Watches the opcode decoded in ID; on HALT it stops fetch, drains in-flight instructions, then freezes. It also counts executed cycles for the debug unit.

Parameters:
- CNT_W, 32, width of the cycle counter.
- DRAIN_CYCLES, 4, cycles needed after HALT is seen in ID to retire older instructions (stages ID..WB).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_op  in  2  command: 00 CLEAR, 01 RUN, 10 STEP, 11 STOP
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- id_valid  in  1  ID stage holds a real (non-bubble) instruction
- id_opcode  in  6  opcode field of the instruction in ID
- pipe_en  out  1  global enable for all pipeline registers and PC
- fetch_en  out  1  PC/IF advance enable
- if_id_flush  out  1  load a bubble into IF/ID on the next enabled edge
- halted  out  1  HALT retired; pipeline frozen
- done  out  1  one-cycle pulse: step finished or drain finished
- cycle_count  out  CNT_W  enabled-cycle counter
- state  out  3  current FSM state, for debug readback

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cycle_count=0, drain_cnt=0, done=0. While reset is held, pipe_en=0, fetch_en=0, if_id_flush=0, halted=0 and cmd_ready=1. Reset asserted mid-RUN or mid-DRAIN aborts immediately; no done pulse is generated.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. Values 5..7 are unreachable and recover to IDLE.
- Outputs are Moore, decoded from state:
  - pipe_en=1 in RUN, STEP, DRAIN.
  - fetch_en=1 in RUN, STEP.
  - if_id_flush=1 in DRAIN.
  - halted=1 in HALTED.
  - cmd_ready=1 in IDLE, RUN, HALTED; 0 in STEP, DRAIN.
- halt_hit = pipe_en && fetch_en && id_valid && (id_opcode==OPCODE_HALT).
- IDLE:
  - RUN accepted -> RUN.
  - STEP accepted -> STEP.
  - CLEAR accepted -> cycle_count=0, stay in IDLE.
  - STOP accepted -> no effect.
- RUN:
  - halt_hit -> DRAIN, drain_cnt=DRAIN_CYCLES.
  - Otherwise STOP accepted -> IDLE.
  - RUN, STEP and CLEAR are accepted and ignored.
  - If halt_hit and STOP arrive in the same cycle, halt_hit wins and the STOP is consumed with no effect.
- STEP: exactly one enabled cycle.
  - halt_hit -> DRAIN.
  - Otherwise -> IDLE with done=1 for one cycle.
- DRAIN:
  - Fetch is stopped, so the instruction after HALT never enters ID; the pipeline keeps advancing.
  - drain_cnt decrements each cycle.
  - When drain_cnt==1 -> HALTED, with done=1 for one cycle.
- HALTED:
  - CLEAR accepted -> IDLE, cycle_count=0.
  - RUN, STEP and STOP are accepted and ignored.
- Latency: a command accepted at edge N is reflected in state and outputs after edge N. The first enabled pipeline edge is N+1.
- cycle_count increments on every edge where pipe_en=1 and saturates at all-ones (no wrap).
- done is registered: high for exactly the cycle after the terminating edge.
- DRAIN_CYCLES=0 is illegal; flag it with an elaboration check.

Decomposition:
- mips_pkg.vh additions:
  - OPCODE_HALT = 6'b111111.
  - CMD_CLEAR/RUN/STEP/STOP encodings.
  - EXEC_IDLE/RUN/STEP/DRAIN/HALTED state encodings.
- Sub-module: sat_counter (parameterised width, enable, sync clear, saturate). Used here for cycle_count and reusable by the debug unit.
- drain_cnt stays inline, width = clog2(DRAIN_CYCLES+1).

Test Plan:
- Reset then RUN: after 10 enabled cycles, issue STOP -> state=IDLE, pipe_en=0, cycle_count=10, no done pulse.
- Three STEP commands from IDLE -> each gives exactly one pipe_en=1 cycle and one done pulse; cycle_count=3; cmd_ready=0 during each STEP cycle.
- RUN, then present id_valid=1, id_opcode=6'b111111 -> next cycle fetch_en=0 and if_id_flush=1. After 4 DRAIN cycles: halted=1, done pulses once, and cycle_count includes the 4 drain cycles.
- Collision: STOP asserted on the same edge as halt_hit -> DRAIN is entered, STOP is discarded, and the sequence ends HALTED.
- In HALTED, issue RUN -> ignored (pipe_en stays 0). Then CLEAR -> IDLE with cycle_count=0.
- Drop rst_n asynchronously mid-DRAIN -> outputs go to reset values immediately, without a clock edge. Force cycle_count to 2^CNT_W-2 in RUN -> it saturates at all-ones.

Source files
------------

// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared encodings for the pipeline execution sequencer: HALT opcode,
// debug-host command codes and sequencer state values.
package pipeline_exec_ctrl_pkg;

   localparam logic [5:0] OPCODE_HALT = 6'b111111;

   typedef enum logic [1:0] {
      CMD_CLEAR = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_STOP  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      EXEC_IDLE   = 3'd0,
      EXEC_RUN    = 3'd1,
      EXEC_STEP   = 3'd2,
      EXEC_DRAIN  = 3'd3,
      EXEC_HALTED = 3'd4
   } exec_state_e;

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones
// instead of wrapping. Reusable by the debug unit.
module pipeline_exec_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage pipeline: takes RUN/STEP/STOP/CLEAR
// from the debug host, gates the pipeline, and drains/freezes on HALT.
module pipeline_exec_ctrl
   import pipeline_exec_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   output logic             cmd_ready,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   output logic             pipe_en,
   output logic             fetch_en,
   output logic             if_id_flush,
   output logic             halted,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count,
   output logic [2:0]       state
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   if (DRAIN_CYCLES < 1) begin : g_bad_drain_cycles
      $error("pipeline_exec_ctrl: DRAIN_CYCLES must be at least 1");
   end

   exec_state_e        state_q;
   logic [DRAIN_W-1:0] drain_cnt_q;
   logic               done_q;

   cmd_e cmd;
   logic cmd_fire;
   logic halt_hit;
   logic clear_fire;

   // Moore decode straight off the state flop, so async reset reaches the outputs at once.
   always_comb begin
      pipe_en     = 1'b0;
      fetch_en    = 1'b0;
      if_id_flush = 1'b0;
      halted      = 1'b0;
      cmd_ready   = 1'b0;
      case (state_q)
         EXEC_IDLE:   cmd_ready = 1'b1;
         EXEC_RUN: begin
            pipe_en   = 1'b1;
            fetch_en  = 1'b1;
            cmd_ready = 1'b1;
         end
         EXEC_STEP: begin
            pipe_en  = 1'b1;
            fetch_en = 1'b1;
         end
         EXEC_DRAIN: begin
            pipe_en     = 1'b1;
            if_id_flush = 1'b1;
         end
         EXEC_HALTED: begin
            halted    = 1'b1;
            cmd_ready = 1'b1;
         end
         default: ;
      endcase
   end

   assign cmd        = cmd_e'(cmd_op);
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign halt_hit   = pipe_en && fetch_en && id_valid && (id_opcode == OPCODE_HALT);
   assign clear_fire = cmd_fire && (cmd == CMD_CLEAR)
                       && ((state_q == EXEC_IDLE) || (state_q == EXEC_HALTED));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EXEC_IDLE;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            EXEC_IDLE: begin
               if (cmd_fire && (cmd == CMD_RUN)) begin
                  state_q <= EXEC_RUN;
               end else if (cmd_fire && (cmd == CMD_STEP)) begin
                  state_q <= EXEC_STEP;
               end
            end
            EXEC_RUN: begin
               // A HALT in ID outranks a simultaneous STOP; the STOP is simply consumed.
               if (halt_hit) begin
                  state_q     <= EXEC_DRAIN;
                  drain_cnt_q <= DRAIN_W'(DRAIN_CYCLES);
               end else if (cmd_fire && (cmd == CMD_STOP)) begin
                  state_q <= EXEC_IDLE;
               end
            end
            EXEC_STEP: begin
               if (halt_hit) begin
                  state_q     <= EXEC_DRAIN;
                  drain_cnt_q <= DRAIN_W'(DRAIN_CYCLES);
               end else begin
                  state_q <= EXEC_IDLE;
                  done_q  <= 1'b1;
               end
            end
            EXEC_DRAIN: begin
               drain_cnt_q <= drain_cnt_q - 1'b1;
               if (drain_cnt_q == DRAIN_W'(1)) begin
                  state_q <= EXEC_HALTED;
                  done_q  <= 1'b1;
               end
            end
            EXEC_HALTED: begin
               if (clear_fire) begin
                  state_q <= EXEC_IDLE;
               end
            end
            default: state_q <= EXEC_IDLE;
         endcase
      end
   end

   pipeline_exec_ctrl_sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (pipe_en),
      .clr_i   (clear_fire),
      .count_o (cycle_count)
   );

   assign done  = done_q;
   assign state = state_q;

endmodule
